// File: rtl/dmem_if.sv
// Load/store port between the MEM stage (master) and the data-memory responder (slave).
interface dmem_if;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        ack_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        stall_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    input  ack_o, rdata_o, err_o, stall_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    output ack_o, rdata_o, err_o, stall_o
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data store answering stage-4 loads/stores after a fixed LATENCY,
// stalling the pipeline while an access is outstanding.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 4
) (
  input  logic   clk_i,
  input  logic   rst_i,
  dmem_if.slave  bus
);
  // state | meaning
  // IDLE  | waiting for req_i; request sampled on the accepting edge
  // BUSY  | counting down the remaining latency
  // RESP  | single ack cycle; req_i ignored
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam int         IDX_W    = $clog2(DEPTH_WORDS);
  localparam bit         DIRECT   = (LATENCY == 1);
  localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               bad_q, bad_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic [31:0]        rdata_q, rdata_d;

  logic [31:0]        mem [DEPTH_WORDS];

  logic               bad_in;
  logic               commit;
  logic               c_we, c_bad;
  logic [IDX_W-1:0]   c_idx;
  logic [31:0]        c_wdata;
  logic               mem_wr;

  assign bad_in = (bus.addr_i[1:0] != 2'b00) ||
                  ({2'b00, bus.addr_i[31:2]} >= 32'(DEPTH_WORDS));

  // With LATENCY 1 the commit happens on the accepting edge, so use the live inputs.
  assign c_we    = DIRECT ? bus.we_i                 : we_q;
  assign c_bad   = DIRECT ? bad_in                   : bad_q;
  assign c_idx   = DIRECT ? bus.addr_i[IDX_W+1:2]    : idx_q;
  assign c_wdata = DIRECT ? bus.wdata_i              : wdata_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    bad_d   = bad_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_i) begin
          we_d    = bus.we_i;
          idx_d   = bus.addr_i[IDX_W+1:2];
          wdata_d = bus.wdata_i;
          bad_d   = bad_in;
          if (DIRECT) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_INIT;
          end
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = RESP;
          commit  = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ack_d = commit;
    if (commit) begin
      if (c_bad) begin
        err_d   = 1'b1;
        rdata_d = 32'd0;
      end else begin
        err_d   = 1'b0;
        rdata_d = c_we ? c_wdata : mem[c_idx];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      bad_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      bad_q   <= bad_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Array is never cleared; a reset held across the commit edge drops the store.
  assign mem_wr = commit && c_we && !c_bad;

  always_ff @(posedge clk_i) begin
    if (mem_wr && !rst_i) begin
      mem[c_idx] <= c_wdata;
    end
  end

  assign bus.ack_o   = ack_q;
  assign bus.err_o   = err_q;
  assign bus.rdata_o = rdata_q;
  assign bus.stall_o = ((state_q == IDLE) && bus.req_i) || (state_q == BUSY);
endmodule

// File: tb/tb_dmem_responder.sv
// Randomised bench for dmem_responder: LATENCY=4 and LATENCY=1 instances checked
// against a word-array reference model.
module tb_dmem_responder;
  logic clk;
  logic rst;

  dmem_if if4 ();
  dmem_if if1 ();

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(4)) u_dut4 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (if4)
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_dut1 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (if1)
  );

  int n_vec;
  int n_err;

  logic [31:0] m4 [256];
  logic [31:0] m1 [256];
  bit          known4 [256];
  bit          known1 [256];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input int sel, input bit req, input bit we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (sel == 1) begin
      if1.req_i = req; if1.we_i = we; if1.addr_i = addr; if1.wdata_i = wdata;
    end else begin
      if4.req_i = req; if4.we_i = we; if4.addr_i = addr; if4.wdata_i = wdata;
    end
  endtask

  function automatic logic rd_ack(input int sel);
    return (sel == 1) ? if1.ack_o : if4.ack_o;
  endfunction

  function automatic logic rd_stall(input int sel);
    return (sel == 1) ? if1.stall_o : if4.stall_o;
  endfunction

  function automatic logic rd_err(input int sel);
    return (sel == 1) ? if1.err_o : if4.err_o;
  endfunction

  function automatic logic [31:0] rd_data(input int sel);
    return (sel == 1) ? if1.rdata_o : if4.rdata_o;
  endfunction

  // One complete access; the request is raised in an IDLE cycle and the task ends
  // on the edge that closes the ack cycle.
  task automatic access(input int sel, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit perturb);
    int          lat;
    int          k;
    int          stalls;
    bit          got;
    bit          bad;
    bit          exp_known;
    int          idx;
    logic [31:0] exp_rd;

    lat = (sel == 1) ? 1 : 4;
    bad = (addr[1:0] != 2'b00) || (addr >= 32'h400);
    idx = int'(addr[9:2]);
    if (bad) begin
      exp_rd = 32'd0; exp_known = 1'b1;
    end else if (we) begin
      exp_rd = wdata; exp_known = 1'b1;
    end else if (sel == 1) begin
      exp_rd = m1[idx]; exp_known = known1[idx];
    end else begin
      exp_rd = m4[idx]; exp_known = known4[idx];
    end

    @(negedge clk);
    drive(sel, 1'b1, we, addr, wdata);
    #1;
    stalls = rd_stall(sel) ? 1 : 0;
    got = 1'b0;
    k = 0;
    while (!got && k < 40) begin
      @(posedge clk);
      #1;
      k++;
      if (rd_ack(sel)) begin
        got = 1'b1;
      end else begin
        if (perturb && k == 1) drive(sel, 1'b1, ~we, $urandom, $urandom);
        if (rd_stall(sel)) stalls++;
      end
    end
    check_val("ack_seen", 32'(got), 32'd1);
    check_val("ack_latency", 32'(k), 32'(lat));
    check_val("stall_cycles", 32'(stalls), 32'(lat));
    check_val("err", 32'(rd_err(sel)), 32'(bad));
    if (exp_known) check_val("rdata", rd_data(sel), exp_rd);
    check_val("stall_in_resp", 32'(rd_stall(sel)), 32'd0);
    drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk);
    #1;
    check_val("ack_one_cycle", 32'(rd_ack(sel)), 32'd0);
    if (exp_known) check_val("rdata_hold", rd_data(sel), exp_rd);

    if (we && !bad) begin
      if (sel == 1) begin
        m1[idx] = wdata; known1[idx] = 1'b1;
      end else begin
        m4[idx] = wdata; known4[idx] = 1'b1;
      end
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 6)      return 32'($urandom_range(0, 15)) << 2;
    else if (r == 7) return (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
    else if (r == 8) return 32'h400 + (32'($urandom_range(0, 255)) << 2);
    else             return $urandom;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 256; i++) begin
      known4[i] = 1'b0;
      known1[i] = 1'b0;
    end
    rst = 1'b1;
    drive(4, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("rst_ack", 32'(if4.ack_o), 32'd0);
    check_val("rst_err", 32'(if4.err_o), 32'd0);
    check_val("rst_rdata", if4.rdata_o, 32'd0);
    check_val("rst_stall", 32'(if4.stall_o), 32'd0);

    // Store/load at LATENCY 4, with an asynchronous reset between them.
    access(4, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_val("midrst_ack", 32'(if4.ack_o), 32'd0);
    check_val("midrst_rdata", if4.rdata_o, 32'd0);
    check_val("midrst_stall", 32'(if4.stall_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    access(4, 1'b0, 32'h10, 32'd0, 1'b0);

    // LATENCY 1.
    access(1, 1'b1, 32'h0, 32'h12345678, 1'b0);
    access(1, 1'b0, 32'h0, 32'd0, 1'b0);

    // Error responses leave the array untouched (0x400 would alias word 0).
    access(4, 1'b1, 32'h0, 32'h0BADF00D, 1'b0);
    access(4, 1'b0, 32'h13, 32'd0, 1'b0);
    access(4, 1'b1, 32'h400, 32'hFFFFFFFF, 1'b0);
    access(4, 1'b0, 32'h0, 32'd0, 1'b0);
    access(1, 1'b1, 32'h400, 32'hFFFFFFFF, 1'b0);
    access(1, 1'b0, 32'h0, 32'd0, 1'b0);

    // Inputs wiggled while BUSY.
    access(4, 1'b1, 32'h24, 32'hCAFEF00D, 1'b1);
    access(4, 1'b0, 32'h24, 32'd0, 1'b1);

    // Reset while a store is in flight.
    access(4, 1'b1, 32'h20, 32'h11111111, 1'b0);
    @(negedge clk);
    drive(4, 1'b1, 1'b1, 32'h20, 32'hA5A5A5A5);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    drive(4, 1'b0, 1'b0, 32'd0, 32'd0);
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (if4.ack_o) acks++;
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (if4.ack_o) acks++;
    end
    check_val("busy_rst_no_ack", 32'(acks), 32'd0);
    access(4, 1'b0, 32'h20, 32'd0, 1'b0);

    for (int i = 0; i < 80; i++) begin
      access(($urandom_range(0, 1) == 1) ? 1 : 4, 1'($urandom_range(0, 1)),
             rand_addr(), $urandom, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
